// File: rtl/pipelined_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_control_unit_if
// Description : Signal bundle between the ID-stage instruction source and the
//               pipelined control unit, plus the per-stage control outputs
//               consumed by the datapath muxes.
//   ID side   : id_valid, Op, Funct, Rs, Rt, Rd, branch_taken
//   Outputs   : stall, illegal_op,
//               ex_alu_ctrl, ex_alu_src, ex_branch, ex_branch_ne,
//               ex_fwd_a, ex_fwd_b,
//               mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_dst,
//               wb_reg_write, wb_mem_to_reg, wb_dst
//   master    : drives the ID side, observes the outputs
//   slave     : the control unit itself
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_control_unit_if #(
    parameter int ALU_W  = 6,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [5:0]        Op;
    logic [5:0]        Funct;
    logic [REG_AW-1:0] Rs;
    logic [REG_AW-1:0] Rt;
    logic [REG_AW-1:0] Rd;
    logic              branch_taken;

    logic              stall;
    logic              illegal_op;
    logic [ALU_W-1:0]  ex_alu_ctrl;
    logic              ex_alu_src;
    logic              ex_branch;
    logic              ex_branch_ne;
    logic [1:0]        ex_fwd_a;
    logic [1:0]        ex_fwd_b;
    logic              mem_mem_write;
    logic              mem_mem_to_reg;
    logic              mem_reg_write;
    logic [REG_AW-1:0] mem_dst;
    logic              wb_reg_write;
    logic              wb_mem_to_reg;
    logic [REG_AW-1:0] wb_dst;

    modport master (
        output id_valid, Op, Funct, Rs, Rt, Rd, branch_taken,
        input  stall, illegal_op,
        input  ex_alu_ctrl, ex_alu_src, ex_branch, ex_branch_ne, ex_fwd_a, ex_fwd_b,
        input  mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_dst,
        input  wb_reg_write, wb_mem_to_reg, wb_dst
    );

    modport slave (
        input  id_valid, Op, Funct, Rs, Rt, Rd, branch_taken,
        output stall, illegal_op,
        output ex_alu_ctrl, ex_alu_src, ex_branch, ex_branch_ne, ex_fwd_a, ex_fwd_b,
        output mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_dst,
        output wb_reg_write, wb_mem_to_reg, wb_dst
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_control_unit
// Description : MIPS pipeline control path. Decodes Op/Funct in ID, carries
//               the control bits through ID/EX, EX/MEM and MEM/WB, detects
//               load-use hazards (stall + EX bubble), squashes the ID
//               instruction on a taken branch and produces EX forwarding
//               selects (00 regfile, 01 WB, 10 MEM).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of pipelined_control_unit_if (ID fields in,
//           per-stage controls out)
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_control_unit #(
    parameter int ALU_W  = 6,
    parameter int REG_AW = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pipelined_control_unit_if.slave       bus
);
    // ID opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ADDIU = 6'b001001;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_SLTIU = 6'b001011;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_XORI  = 6'b001110;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LB    = 6'b100000;
    localparam logic [5:0] c_OP_LH    = 6'b100001;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_LBU   = 6'b100100;
    localparam logic [5:0] c_OP_LHU   = 6'b100101;
    localparam logic [5:0] c_OP_LWU   = 6'b100111;
    localparam logic [5:0] c_OP_SB    = 6'b101000;
    localparam logic [5:0] c_OP_SH    = 6'b101001;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    // ALU control codes
    localparam logic [5:0] c_ALU_ADD  = 6'b100000;
    localparam logic [5:0] c_ALU_ADDU = 6'b100001;
    localparam logic [5:0] c_ALU_SUB  = 6'b100010;
    localparam logic [5:0] c_ALU_AND  = 6'b100100;
    localparam logic [5:0] c_ALU_OR   = 6'b100101;
    localparam logic [5:0] c_ALU_XOR  = 6'b100110;
    localparam logic [5:0] c_ALU_SLT  = 6'b101010;
    localparam logic [5:0] c_ALU_SLTU = 6'b101011;
    localparam logic [5:0] c_ALU_LUI  = 6'b001111;

    typedef struct packed {
        logic              valid;
        logic [5:0]        alu;
        logic              alu_src;
        logic              branch;
        logic              branch_ne;
        logic              mem_write;
        logic              mem_to_reg;
        logic              reg_write;
        logic [REG_AW-1:0] dst;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
    } ex_t;

    // ---------------------------------------------------------------- decode
    logic [5:0] w_alu;
    logic       w_alu_src, w_reg_dst, w_reg_write, w_mem_to_reg, w_mem_write;
    logic       w_branch, w_branch_ne, w_uses_rt, w_legal;

    always_comb begin
        w_alu        = 6'b0;
        w_alu_src    = 1'b0;
        w_reg_dst    = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_mem_write  = 1'b0;
        w_branch     = 1'b0;
        w_branch_ne  = 1'b0;
        w_uses_rt    = 1'b0;
        w_legal      = 1'b1;
        case (bus.Op)
            c_OP_RTYPE: begin
                w_alu = bus.Funct; w_reg_dst = 1'b1; w_reg_write = 1'b1; w_uses_rt = 1'b1;
            end
            c_OP_ADDI:  begin w_alu = c_ALU_ADD;  w_alu_src = 1'b1; w_reg_write = 1'b1; end
            c_OP_ADDIU: begin w_alu = c_ALU_ADDU; w_alu_src = 1'b1; w_reg_write = 1'b1; end
            c_OP_ANDI:  begin w_alu = c_ALU_AND;  w_alu_src = 1'b1; w_reg_write = 1'b1; end
            c_OP_ORI:   begin w_alu = c_ALU_OR;   w_alu_src = 1'b1; w_reg_write = 1'b1; end
            c_OP_XORI:  begin w_alu = c_ALU_XOR;  w_alu_src = 1'b1; w_reg_write = 1'b1; end
            c_OP_SLTI:  begin w_alu = c_ALU_SLT;  w_alu_src = 1'b1; w_reg_write = 1'b1; end
            c_OP_SLTIU: begin w_alu = c_ALU_SLTU; w_alu_src = 1'b1; w_reg_write = 1'b1; end
            c_OP_LUI:   begin w_alu = c_ALU_LUI;  w_alu_src = 1'b1; w_reg_write = 1'b1; end
            c_OP_LB, c_OP_LH, c_OP_LW: begin
                w_alu = c_ALU_ADD; w_alu_src = 1'b1; w_mem_to_reg = 1'b1; w_reg_write = 1'b1;
            end
            c_OP_LBU, c_OP_LHU, c_OP_LWU: begin
                w_alu = c_ALU_ADDU; w_alu_src = 1'b1; w_mem_to_reg = 1'b1; w_reg_write = 1'b1;
            end
            c_OP_SB, c_OP_SH, c_OP_SW: begin
                w_alu = c_ALU_ADD; w_alu_src = 1'b1; w_mem_write = 1'b1; w_uses_rt = 1'b1;
            end
            c_OP_BEQ: begin w_alu = c_ALU_SUB; w_branch = 1'b1; w_uses_rt = 1'b1; end
            c_OP_BNE: begin
                w_alu = c_ALU_SUB; w_branch = 1'b1; w_branch_ne = 1'b1; w_uses_rt = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------- pipeline state
    // Bubbles are all-zero records, so MEM/WB need no separate valid bit.
    ex_t               r_ex;
    logic              r_mem_mem_write, r_mem_mem_to_reg, r_mem_reg_write;
    logic [REG_AW-1:0] r_mem_dst;
    logic              r_wb_reg_write, r_wb_mem_to_reg;
    logic [REG_AW-1:0] r_wb_dst;

    // ------------------------------------------------------------- hazard
    logic w_haz, w_ex_load;
    ex_t  w_ex_next;

    assign w_haz = bus.id_valid & r_ex.valid & r_ex.mem_to_reg & r_ex.reg_write
                 & (r_ex.dst != '0)
                 & ((r_ex.dst == bus.Rs) | (w_uses_rt & (r_ex.dst == bus.Rt)));

    // A taken branch squashes the ID instruction, which makes any stall moot.
    assign bus.stall = w_haz & ~bus.branch_taken;

    // Illegal opcodes enter EX as a full bubble so nothing downstream reacts.
    assign w_ex_load      = bus.id_valid & w_legal & ~w_haz & ~bus.branch_taken;
    assign bus.illegal_op = bus.id_valid & ~w_legal;

    always_comb begin
        w_ex_next = '0;
        if (w_ex_load) begin
            w_ex_next.valid      = 1'b1;
            w_ex_next.alu        = w_alu;
            w_ex_next.alu_src    = w_alu_src;
            w_ex_next.branch     = w_branch;
            w_ex_next.branch_ne  = w_branch_ne;
            w_ex_next.mem_write  = w_mem_write;
            w_ex_next.mem_to_reg = w_mem_to_reg;
            w_ex_next.reg_write  = w_reg_write;
            w_ex_next.dst        = w_reg_dst ? bus.Rd : bus.Rt;
            w_ex_next.rs         = bus.Rs;
            w_ex_next.rt         = bus.Rt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex             <= '0;
            r_mem_mem_write  <= 1'b0;
            r_mem_mem_to_reg <= 1'b0;
            r_mem_reg_write  <= 1'b0;
            r_mem_dst        <= '0;
            r_wb_reg_write   <= 1'b0;
            r_wb_mem_to_reg  <= 1'b0;
            r_wb_dst         <= '0;
        end else begin
            r_ex             <= w_ex_next;
            r_mem_mem_write  <= r_ex.mem_write;
            r_mem_mem_to_reg <= r_ex.mem_to_reg;
            r_mem_reg_write  <= r_ex.reg_write;
            r_mem_dst        <= r_ex.dst;
            r_wb_reg_write   <= r_mem_reg_write;
            r_wb_mem_to_reg  <= r_mem_mem_to_reg;
            r_wb_dst         <= r_mem_dst;
        end
    end

    // ---------------------------------------------------------- forwarding
    // r0 is never forwarded; the newer (MEM) result wins over WB.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              mem_rw, input logic [REG_AW-1:0] mem_dst,
        input logic              wb_rw,  input logic [REG_AW-1:0] wb_dst
    );
        if (mem_rw && (mem_dst != '0) && (mem_dst == src))
            return 2'b10;
        else if (wb_rw && (wb_dst != '0) && (wb_dst == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign bus.ex_fwd_a = fwd_sel(r_ex.rs, r_mem_reg_write, r_mem_dst, r_wb_reg_write, r_wb_dst);
    assign bus.ex_fwd_b = fwd_sel(r_ex.rt, r_mem_reg_write, r_mem_dst, r_wb_reg_write, r_wb_dst);

    // ------------------------------------------------------------- outputs
    assign bus.ex_alu_ctrl    = ALU_W'(r_ex.alu);
    assign bus.ex_alu_src     = r_ex.alu_src;
    assign bus.ex_branch      = r_ex.branch;
    assign bus.ex_branch_ne   = r_ex.branch_ne;
    assign bus.mem_mem_write  = r_mem_mem_write;
    assign bus.mem_mem_to_reg = r_mem_mem_to_reg;
    assign bus.mem_reg_write  = r_mem_reg_write;
    assign bus.mem_dst        = r_mem_dst;
    assign bus.wb_reg_write   = r_wb_reg_write;
    assign bus.wb_mem_to_reg  = r_wb_mem_to_reg;
    assign bus.wb_dst         = r_wb_dst;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_control_unit
// Description : Self-checking bench for pipelined_control_unit. A reference
//               model classifies each instruction and tracks what sits in
//               EX/MEM/WB; every falling edge all outputs are compared to it.
//               Directed scenarios pin literal values, then randomized
//               instruction streams (with branches and async resets) follow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_control_unit;
    localparam int ALU_W  = 6;
    localparam int REG_AW = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_control_unit_if #(.ALU_W(ALU_W), .REG_AW(REG_AW)) bus ();

    pipelined_control_unit #(.ALU_W(ALU_W), .REG_AW(REG_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------- reference model
    typedef struct packed {
        bit       v;
        bit [5:0] alu;
        bit       src, br, bne, mw, m2r, rw;
        bit [4:0] dst, rs, rt;
    } stg_t;

    stg_t m_ex, m_mem, m_wb;

    // Instruction classes: what an instruction does, independent of encoding.
    typedef enum int { K_R, K_IMM, K_LOAD, K_STORE, K_BEQ, K_BNE, K_ILL } kind_t;

    function automatic void classify(input bit [5:0] op, output kind_t k, output bit [5:0] alu);
        alu = 6'd0;
        case (op)
            6'd0:  k = K_R;
            6'd8:  begin k = K_IMM;   alu = 6'd32; end
            6'd9:  begin k = K_IMM;   alu = 6'd33; end
            6'd10: begin k = K_IMM;   alu = 6'd42; end
            6'd11: begin k = K_IMM;   alu = 6'd43; end
            6'd12: begin k = K_IMM;   alu = 6'd36; end
            6'd13: begin k = K_IMM;   alu = 6'd37; end
            6'd14: begin k = K_IMM;   alu = 6'd38; end
            6'd15: begin k = K_IMM;   alu = 6'd15; end
            6'd32, 6'd33, 6'd35: begin k = K_LOAD; alu = 6'd32; end
            6'd36, 6'd37, 6'd39: begin k = K_LOAD; alu = 6'd33; end
            6'd40, 6'd41, 6'd43: begin k = K_STORE; alu = 6'd32; end
            6'd4:  begin k = K_BEQ;   alu = 6'd34; end
            6'd5:  begin k = K_BNE;   alu = 6'd34; end
            default: k = K_ILL;
        endcase
    endfunction

    function automatic void mdecode(input bit [5:0] op, input bit [5:0] fn,
                                    input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                                    output stg_t s, output bit legal, output bit urt);
        kind_t k;
        bit [5:0] a;
        classify(op, k, a);
        s     = '0;
        legal = (k != K_ILL);
        urt   = (k == K_R) || (k == K_STORE) || (k == K_BEQ) || (k == K_BNE);
        if (legal) begin
            s.v   = 1'b1;
            s.alu = (k == K_R) ? fn : a;
            s.src = (k == K_IMM) || (k == K_LOAD) || (k == K_STORE);
            s.br  = (k == K_BEQ) || (k == K_BNE);
            s.bne = (k == K_BNE);
            s.mw  = (k == K_STORE);
            s.m2r = (k == K_LOAD);
            s.rw  = (k == K_R) || (k == K_IMM) || (k == K_LOAD);
            s.dst = (k == K_R) ? rd : rt;
            s.rs  = rs;
            s.rt  = rt;
        end
    endfunction

    function automatic bit m_hazard(input bit urt);
        return bus.id_valid && m_ex.v && m_ex.m2r && m_ex.rw && (m_ex.dst != 0) &&
               ((m_ex.dst == bus.Rs) || (urt && (m_ex.dst == bus.Rt)));
    endfunction

    function automatic int m_fwd(input bit [4:0] r);
        if (m_mem.rw && m_mem.dst != 0 && m_mem.dst == r) return 2;
        if (m_wb.rw  && m_wb.dst  != 0 && m_wb.dst  == r) return 1;
        return 0;
    endfunction

    function automatic bit m_stall();
        stg_t d; bit lg, u;
        mdecode(bus.Op, bus.Funct, bus.Rs, bus.Rt, bus.Rd, d, lg, u);
        return m_hazard(u) && !bus.branch_taken;
    endfunction

    stg_t md;
    bit   mlg, mu;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex  = '0;
            m_mem = '0;
            m_wb  = '0;
        end else begin
            mdecode(bus.Op, bus.Funct, bus.Rs, bus.Rt, bus.Rd, md, mlg, mu);
            m_wb  = m_mem;
            m_mem = m_ex;
            if (bus.id_valid && mlg && !bus.branch_taken && !m_hazard(mu))
                m_ex = md;
            else
                m_ex = '0;
        end
    end

    // ------------------------------------------------------ compare process
    stg_t cd;
    bit   clg, cu;
    always @(negedge clk) begin
        mdecode(bus.Op, bus.Funct, bus.Rs, bus.Rt, bus.Rd, cd, clg, cu);
        chk("stall",          bus.stall,          int'(m_hazard(cu) && !bus.branch_taken));
        chk("illegal_op",     bus.illegal_op,     int'(bus.id_valid && !clg));
        chk("ex_alu_ctrl",    bus.ex_alu_ctrl,    m_ex.alu);
        chk("ex_alu_src",     bus.ex_alu_src,     m_ex.src);
        chk("ex_branch",      bus.ex_branch,      m_ex.br);
        chk("ex_branch_ne",   bus.ex_branch_ne,   m_ex.bne);
        chk("ex_fwd_a",       bus.ex_fwd_a,       m_fwd(m_ex.rs));
        chk("ex_fwd_b",       bus.ex_fwd_b,       m_fwd(m_ex.rt));
        chk("mem_mem_write",  bus.mem_mem_write,  m_mem.mw);
        chk("mem_mem_to_reg", bus.mem_mem_to_reg, m_mem.m2r);
        chk("mem_reg_write",  bus.mem_reg_write,  m_mem.rw);
        chk("mem_dst",        bus.mem_dst,        m_mem.dst);
        chk("wb_reg_write",   bus.wb_reg_write,   m_wb.rw);
        chk("wb_mem_to_reg",  bus.wb_mem_to_reg,  m_wb.m2r);
        chk("wb_dst",         bus.wb_dst,         m_wb.dst);
    end

    // -------------------------------------------------------------- stimulus
    task automatic drive(input bit v, input bit [5:0] op, input bit [5:0] fn,
                         input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                         input bit bt);
        bus.id_valid     = v;
        bus.Op           = op;
        bus.Funct        = fn;
        bus.Rs           = rs;
        bus.Rt           = rt;
        bus.Rd           = rd;
        bus.branch_taken = bt;
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int unsigned ops[26] = '{0, 0, 0, 8, 9, 10, 11, 12, 13, 14, 15, 32, 33, 35, 36, 37,
                             39, 40, 41, 43, 4, 5, 35, 35, 63, 2};
    int unsigned fns[5]  = '{32, 34, 36, 37, 42};

    initial begin
        bit hold;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall",    bus.stall,         0);
        chk("reset_fwd_a",    bus.ex_fwd_a,      0);
        chk("reset_wb_rw",    bus.wb_reg_write,  0);
        rst_n = 1'b1;

        // LW r2 ; ADD r3,r2,r4 -> one stall cycle, bubble, then forward from WB
        drive(1, 6'd35, 6'd0, 5'd1, 5'd2, 5'd0, 0); step();
        drive(1, 6'd0, 6'd32, 5'd2, 5'd4, 5'd3, 0); #1;
        chk("lu_stall", bus.stall, 1);
        step(); #1;
        chk("lu_stall_released", bus.stall, 0);
        chk("lu_bubble_alu_src", bus.ex_alu_src, 0);
        chk("lu_load_in_mem",    bus.mem_mem_to_reg, 1);
        step(); idle(); #1;
        chk("lu_fwd_a_wb",  bus.ex_fwd_a, 1);
        chk("lu_add_alu",   bus.ex_alu_ctrl, 32);
        chk("lu_wb_m2r",    bus.wb_mem_to_reg, 1);

        // ADD r1,r2,r3 ; SUB r5,r1,r1 -> no stall, both operands from MEM
        drive(1, 6'd0, 6'd32, 5'd2, 5'd3, 5'd1, 0); step();
        drive(1, 6'd0, 6'd34, 5'd1, 5'd1, 5'd5, 0); #1;
        chk("alu_no_stall", bus.stall, 0);
        step(); idle(); #1;
        chk("alu_fwd_a_mem", bus.ex_fwd_a, 2);
        chk("alu_fwd_b_mem", bus.ex_fwd_b, 2);
        chk("sub_alu",       bus.ex_alu_ctrl, 34);

        // LW r0 then use of r0 -> never a hazard, never forwarded
        drive(1, 6'd35, 6'd0, 5'd1, 5'd0, 5'd0, 0); step();
        drive(1, 6'd0, 6'd32, 5'd0, 5'd0, 5'd3, 0); #1;
        chk("r0_no_stall", bus.stall, 0);
        step(); idle(); #1;
        chk("r0_no_fwd", bus.ex_fwd_a, 0);

        // BNE reaches EX; then load-use in ID coinciding with a taken branch
        drive(1, 6'd5, 6'd0, 5'd5, 5'd6, 5'd0, 0); step();
        drive(1, 6'd35, 6'd0, 5'd1, 5'd9, 5'd0, 0); #1;
        chk("bne_ex_branch_ne", bus.ex_branch_ne, 1);
        chk("bne_ex_branch",    bus.ex_branch, 1);
        chk("bne_alu",          bus.ex_alu_ctrl, 34);
        step();
        drive(1, 6'd0, 6'd32, 5'd9, 5'd9, 5'd3, 1); #1;
        chk("flush_no_stall", bus.stall, 0);
        step(); idle(); #1;
        chk("flush_bubble_alu", bus.ex_alu_ctrl, 0);
        chk("flush_load_mem",   bus.mem_mem_to_reg, 1);

        // SW r7 then an illegal opcode
        drive(1, 6'd43, 6'd0, 5'd1, 5'd7, 5'd0, 0); step();
        drive(1, 6'd63, 6'd0, 5'd7, 5'd7, 5'd7, 0); #1;
        chk("illegal_flag", bus.illegal_op, 1);
        step(); idle(); #1;
        chk("sw_mem_write", bus.mem_mem_write, 1);
        chk("sw_no_regwr",  bus.mem_reg_write, 0);
        chk("sw_mem_dst",   bus.mem_dst, 7);
        chk("ill_ex_alu",   bus.ex_alu_ctrl, 0);
        chk("ill_ex_src",   bus.ex_alu_src, 0);
        chk("ill_ex_fwd_a", bus.ex_fwd_a, 0);

        // Three valid instructions in flight, then an asynchronous reset
        drive(1, 6'd8,  6'd0, 5'd1, 5'd1, 5'd0, 0); step();
        drive(1, 6'd13, 6'd0, 5'd2, 5'd2, 5'd0, 0); step();
        drive(1, 6'd35, 6'd0, 5'd3, 5'd3, 5'd0, 0); step();
        idle(); #1;
        chk("pre_rst_wb_rw", bus.wb_reg_write, 1);
        rst_n = 1'b0; #1;
        chk("rst_mem_rw", bus.mem_reg_write, 0);
        chk("rst_wb_rw",  bus.wb_reg_write, 0);
        chk("rst_ex_src", bus.ex_alu_src, 0);
        chk("rst_wb_dst", bus.wb_dst, 0);
        step(); rst_n = 1'b1;

        // Randomized streams; the ID instruction is held while stalled
        hold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!hold)
                drive(($urandom_range(0, 99) < 85),
                      6'(ops[$urandom_range(0, 25)]), 6'(fns[$urandom_range(0, 4)]),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), ($urandom_range(0, 99) < 15));
            else
                bus.branch_taken = ($urandom_range(0, 99) < 15);
            #1;
            hold = m_stall();
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0; #1; rst_n = 1'b1;
                hold = 1'b0;
            end
            step();
        end

        idle();
        step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
